// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI read slave: bus widths, burst and response
// encodings, the read FSM state type and a WRAP-length legality helper.
// No ports (package).
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10,
        BurstRsvd  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StBeat
    } rd_state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_rd_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_rd_addr_gen
// Combinational next-beat address for an AXI read burst.
// Ports:
//   i_addr       current beat byte address
//   i_size       log2 of bytes per beat
//   i_len        burst length minus one
//   i_burst      burst type (FIXED / INCR / WRAP / reserved)
//   o_next_addr  address of the following beat
// -----------------------------------------------------------------------------
module axi_rd_addr_gen
    import axi_pkg::*;
(
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [2:0]           i_size,
    input  logic [3:0]           i_len,
    input  logic [1:0]           i_burst,
    output logic [AddrWidth-1:0] o_next_addr
);

    logic [AddrWidth-1:0] w_incr;
    logic [AddrWidth-1:0] w_sum;
    logic [AddrWidth-1:0] w_wrap_mask;

    always_comb begin
        w_incr      = AddrWidth'(1) << i_size;
        w_sum       = i_addr + w_incr;
        // Container is (len+1) beats wide; only power-of-two lengths reach here
        // with a valid response, so the mask form is exact for those.
        w_wrap_mask = ((AddrWidth'(i_len) + AddrWidth'(1)) << i_size) - AddrWidth'(1);
        unique case (i_burst)
            BurstIncr: o_next_addr = w_sum;
            BurstWrap: o_next_addr = (i_addr & ~w_wrap_mask) | (w_sum & w_wrap_mask);
            default:   o_next_addr = i_addr;
        endcase
    end

endmodule

// File: rtl/axi_read_slave.sv
// -----------------------------------------------------------------------------
// axi_read_slave
// AXI read-channel slave backed by a small word memory with a backdoor loader.
// Ports:
//   G_clk, G_reset                 clock, synchronous active-high reset
//   ARADDR/ARLEN/ARSIZE/ARBURST    read address channel payload
//   ARVALID/ARREADY                read address handshake
//   RVALID/RREADY/RLAST/RRESP/RDATA read data channel
//   slave_addr1, slave_addr2       inclusive decode window for the start address
//   LD_EN, LD_ADDR, LD_DATA        backdoor word write into storage
// -----------------------------------------------------------------------------
module axi_read_slave
    import axi_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 16,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                 G_clk,
    input  logic                 G_reset,
    input  logic [AddrWidth-1:0] ARADDR,
    input  logic [3:0]           ARLEN,
    input  logic [2:0]           ARSIZE,
    input  logic [1:0]           ARBURST,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    input  logic                 RREADY,
    output logic                 RVALID,
    output logic                 RLAST,
    output logic [1:0]           RRESP,
    output logic [DataWidth-1:0] RDATA,
    input  logic [AddrWidth-1:0] slave_addr1,
    input  logic [AddrWidth-1:0] slave_addr2,
    input  logic                 LD_EN,
    input  logic [7:0]           LD_ADDR,
    input  logic [DataWidth-1:0] LD_DATA
);

    localparam int unsigned IdxW  = $clog2(MEM_WORDS);
    localparam logic [1:0]  LatM1 = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    rd_state_e            r_state;
    rd_state_e            w_state_next;
    logic [AddrWidth-1:0] r_addr;
    logic [3:0]           r_len;
    logic [2:0]           r_size;
    logic [1:0]           r_burst;
    logic [1:0]           r_resp;
    logic [3:0]           r_beat;
    logic [1:0]           r_wait;
    logic [DataWidth-1:0] r_rdata;
    logic [DataWidth-1:0] r_mem [MEM_WORDS];

    logic [AddrWidth-1:0] w_next_addr;
    logic [AddrWidth-1:0] w_cap_addr;
    logic [1:0]           w_cap_resp;
    logic [1:0]           w_ar_resp;
    logic                 w_capture;
    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic                 w_last;
    logic                 w_unused_bits;

    assign w_ar_hs = (r_state == StIdle) && ARVALID;
    assign w_r_hs  = (r_state == StBeat) && RREADY;
    assign w_last  = (r_beat == r_len);

    // Decode error takes priority over any protocol error.
    always_comb begin
        w_ar_resp = RespOkay;
        if ((ARADDR < slave_addr1) || (ARADDR > slave_addr2)) begin
            w_ar_resp = RespDecerr;
        end else if ((ARSIZE > 3'd2) || (ARBURST == BurstRsvd) ||
                     ((ARBURST == BurstWrap) && !wrap_len_ok(ARLEN))) begin
            w_ar_resp = RespSlverr;
        end
    end

    axi_rd_addr_gen u_addr_gen (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    // Next state plus the data-capture strobe; data is latched on the edge that
    // enters StBeat, so the capture address depends on where we come from.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_cap_addr   = r_addr;
        w_cap_resp   = r_resp;
        unique case (r_state)
            StIdle: begin
                w_cap_addr = ARADDR;
                w_cap_resp = w_ar_resp;
                if (ARVALID) begin
                    w_state_next = (RD_LAT == 0) ? StBeat : StWait;
                    w_capture    = (RD_LAT == 0);
                end
            end
            StWait: begin
                if (r_wait == 2'd0) begin
                    w_state_next = StBeat;
                    w_capture    = 1'b1;
                end
            end
            StBeat: begin
                w_cap_addr = w_next_addr;
                if (RREADY) begin
                    if (w_last) begin
                        w_state_next = StIdle;
                    end else if (RD_LAT == 0) begin
                        w_state_next = StBeat;
                        w_capture    = 1'b1;
                    end else begin
                        w_state_next = StWait;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge G_clk) begin
        if (G_reset) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_resp  <= RespOkay;
            r_beat  <= '0;
            r_wait  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_ar_hs) begin
                r_addr  <= ARADDR;
                r_len   <= ARLEN;
                r_size  <= ARSIZE;
                r_burst <= ARBURST;
                r_resp  <= w_ar_resp;
                r_beat  <= '0;
            end else if (w_r_hs && !w_last) begin
                r_addr <= w_next_addr;
                r_beat <= r_beat + 4'd1;
            end
            if (w_state_next == StWait) begin
                r_wait <= (r_state == StWait) ? (r_wait - 2'd1) : LatM1;
            end
            if (w_capture) begin
                r_rdata <= (w_cap_resp == RespOkay) ? r_mem[w_cap_addr[IdxW+1:2]] : '0;
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge G_clk) begin
        if (LD_EN) begin
            r_mem[LD_ADDR[IdxW-1:0]] <= LD_DATA;
        end
    end

    assign w_unused_bits = ^{LD_ADDR, w_cap_addr};

    assign ARREADY = (r_state == StIdle);
    assign RVALID  = (r_state == StBeat);
    assign RLAST   = RVALID && w_last;
    assign RRESP   = RVALID ? r_resp : RespOkay;
    assign RDATA   = RVALID ? r_rdata : '0;

endmodule

// File: tb/tb_axi_read_slave.sv
module tb_axi_read_slave;

    localparam int unsigned MemWords = 16;
    localparam int unsigned RdLat    = 1;

    logic        G_clk = 1'b0;
    logic        G_reset;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic        RREADY;
    logic        RVALID;
    logic        RLAST;
    logic [1:0]  RRESP;
    logic [31:0] RDATA;
    logic [31:0] slave_addr1;
    logic [31:0] slave_addr2;
    logic        LD_EN;
    logic [7:0]  LD_ADDR;
    logic [31:0] LD_DATA;

    axi_read_slave #(
        .MEM_WORDS (MemWords),
        .RD_LAT    (RdLat)
    ) dut (
        .G_clk       (G_clk),
        .G_reset     (G_reset),
        .ARADDR      (ARADDR),
        .ARLEN       (ARLEN),
        .ARSIZE      (ARSIZE),
        .ARBURST     (ARBURST),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RREADY      (RREADY),
        .RVALID      (RVALID),
        .RLAST       (RLAST),
        .RRESP       (RRESP),
        .RDATA       (RDATA),
        .slave_addr1 (slave_addr1),
        .slave_addr2 (slave_addr2),
        .LD_EN       (LD_EN),
        .LD_ADDR     (LD_ADDR),
        .LD_DATA     (LD_DATA)
    );

    always #5 G_clk = ~G_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: storage image and expected beats of the current burst.
    logic [31:0] mem_model [MemWords];
    logic [31:0] exp_data [16];
    logic [1:0]  exp_resp;
    int          exp_n;

    typedef struct {
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [1:0]       resp;
        logic [3:0][31:0] data;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk_vec(input logic [31:0] addr, input logic [3:0] len,
                                    input logic [2:0] size, input logic [1:0] burst,
                                    input logic [1:0] resp, input logic [3:0][31:0] data);
        vec_t v;
        v.addr  = addr;
        v.len   = len;
        v.size  = size;
        v.burst = burst;
        v.resp  = resp;
        v.data  = data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout expected response", name);
    endtask

    // Expected beats from the burst rules: address sequence by plain arithmetic.
    task automatic model_burst(input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] bytes;
        logic [31:0] cont;
        logic [31:0] base;
        logic [31:0] a;
        int          idx;
        exp_n = int'(len) + 1;
        if (addr < slave_addr1 || addr > slave_addr2) begin
            exp_resp = 2'b11;
        end else if (size > 3'd2 || burst == 2'b11 ||
                     (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15))) begin
            exp_resp = 2'b10;
        end else begin
            exp_resp = 2'b00;
        end
        bytes = 32'd1 << size;
        cont  = bytes * (32'(len) + 32'd1);
        base  = addr - (addr % cont);
        for (int i = 0; i < exp_n; i++) begin
            case (burst)
                2'b00:   a = addr;
                2'b01:   a = addr + 32'(i) * bytes;
                default: a = base + ((addr - base + 32'(i) * bytes) % cont);
            endcase
            idx = int'((a >> 2) % MemWords);
            exp_data[i] = (exp_resp == 2'b00) ? mem_model[idx] : 32'h0;
        end
    endtask

    task automatic load_word(input logic [7:0] la, input logic [31:0] d);
        @(negedge G_clk);
        LD_EN   = 1'b1;
        LD_ADDR = la;
        LD_DATA = d;
        @(negedge G_clk);
        LD_EN = 1'b0;
        mem_model[int'(la) % MemWords] = d;
    endtask

    // Presents one AR request, then scrambles the AR inputs; returns on a negedge.
    task automatic issue_ar(input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        @(negedge G_clk);
        check("arready_idle", 32'(ARREADY), 32'd1);
        ARADDR  = addr;
        ARLEN   = len;
        ARSIZE  = size;
        ARBURST = burst;
        ARVALID = 1'b1;
        @(posedge G_clk);
        #1;
        ARVALID = 1'b0;
        ARADDR  = $urandom;
        ARLEN   = 4'($urandom);
        ARSIZE  = 3'($urandom);
        ARBURST = 2'($urandom);
        @(negedge G_clk);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!RVALID && k < 10) begin
            @(negedge G_clk);
            k++;
        end
        if (!RVALID) fail_timeout(name);
    endtask

    // Consumes exp_n beats starting at the current negedge, checking each one.
    task automatic collect_beats(input bit rnd);
        int beat = 0;
        int cyc  = 0;
        while (beat < exp_n && cyc < 400) begin
            RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            check("arready_busy", 32'(ARREADY), 32'd0);
            if (RVALID && RREADY) begin
                check($sformatf("beat%0d_data", beat), RDATA, exp_data[beat]);
                check($sformatf("beat%0d_resp", beat), 32'(RRESP), 32'(exp_resp));
                check($sformatf("beat%0d_last", beat), 32'(RLAST), 32'(beat == exp_n - 1));
                beat++;
            end
            @(negedge G_clk);
            cyc++;
        end
        RREADY = 1'b0;
        if (beat < exp_n) begin
            fail_timeout("burst_beats");
        end else begin
            check("rvalid_after_last", 32'(RVALID), 32'd0);
            check("arready_after_last", 32'(ARREADY), 32'd1);
        end
    endtask

    task automatic run_model_burst(input logic [31:0] addr, input logic [3:0] len,
                                   input logic [2:0] size, input logic [1:0] burst,
                                   input bit rnd);
        model_burst(addr, len, size, burst);
        issue_ar(addr, len, size, burst);
        collect_beats(rnd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        G_reset     = 1'b1;
        ARADDR      = '0;
        ARLEN       = '0;
        ARSIZE      = '0;
        ARBURST     = '0;
        ARVALID     = 1'b0;
        RREADY      = 1'b0;
        slave_addr1 = 32'h0;
        slave_addr2 = 32'h3F;
        LD_EN       = 1'b0;
        LD_ADDR     = '0;
        LD_DATA     = '0;

        repeat (3) @(negedge G_clk);
        check("rst_arready", 32'(ARREADY), 32'd1);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_rlast", 32'(RLAST), 32'd0);
        check("rst_rresp", 32'(RRESP), 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        G_reset = 1'b0;

        for (int i = 0; i < int'(MemWords); i++) load_word(8'(i), 32'hA0 + 32'(i));

        // Directed table: addr, len, size, burst, resp, beat data (index 0 first).
        vecs[0] = mk_vec(32'h00, 4'd3, 3'd2, 2'b01, 2'b00, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        vecs[1] = mk_vec(32'h08, 4'd3, 3'd2, 2'b10, 2'b00, {32'hA1, 32'hA0, 32'hA3, 32'hA2});
        vecs[2] = mk_vec(32'h100, 4'd1, 3'd2, 2'b01, 2'b11, {32'h0, 32'h0, 32'h0, 32'h0});
        vecs[3] = mk_vec(32'h00, 4'd0, 3'd3, 2'b01, 2'b10, {32'h0, 32'h0, 32'h0, 32'h0});
        vecs[4] = mk_vec(32'h00, 4'd1, 3'd2, 2'b11, 2'b10, {32'h0, 32'h0, 32'h0, 32'h0});
        vecs[5] = mk_vec(32'h00, 4'd2, 3'd2, 2'b10, 2'b10, {32'h0, 32'h0, 32'h0, 32'h0});
        vecs[6] = mk_vec(32'h14, 4'd2, 3'd2, 2'b00, 2'b00, {32'h0, 32'hA5, 32'hA5, 32'hA5});
        vecs[7] = mk_vec(32'h03, 4'd2, 3'd0, 2'b01, 2'b00, {32'h0, 32'hA1, 32'hA1, 32'hA0});

        for (int v = 0; v < 8; v++) begin
            exp_n    = int'(vecs[v].len) + 1;
            exp_resp = vecs[v].resp;
            for (int i = 0; i < 4; i++) exp_data[i] = vecs[v].data[i];
            issue_ar(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
            collect_beats(1'b0);
        end

        // Back-pressure on the first beat: outputs must hold for 5 cycles.
        RREADY = 1'b0;
        issue_ar(32'h0, 4'd3, 3'd2, 2'b01);
        wait_valid("stall_first_beat");
        for (int k = 0; k < 5; k++) begin
            check("stall_rvalid", 32'(RVALID), 32'd1);
            check("stall_rdata", RDATA, 32'hA0);
            check("stall_rlast", 32'(RLAST), 32'd0);
            check("stall_arready", 32'(ARREADY), 32'd0);
            @(negedge G_clk);
        end
        exp_n    = 4;
        exp_resp = 2'b00;
        for (int i = 0; i < 4; i++) exp_data[i] = 32'hA0 + 32'(i);
        collect_beats(1'b0);

        // Reset while beat 2 of 4 is presented.
        RREADY = 1'b1;
        issue_ar(32'h0, 4'd3, 3'd2, 2'b01);
        wait_valid("rst_beat1");
        @(negedge G_clk);
        wait_valid("rst_beat2");
        check("rst_mid_rdata", RDATA, 32'hA1);
        G_reset = 1'b1;
        @(negedge G_clk);
        G_reset = 1'b0;
        RREADY  = 1'b0;
        check("rst_mid_rvalid", 32'(RVALID), 32'd0);
        check("rst_mid_arready", 32'(ARREADY), 32'd1);
        check("rst_mid_rdata0", RDATA, 32'd0);
        check("rst_mid_rlast", 32'(RLAST), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge G_clk);
            check("rst_no_more_beats", 32'(RVALID), 32'd0);
        end
        run_model_burst(32'h0, 4'd3, 3'd2, 2'b01, 1'b0);

        // Backdoor load colliding with the capture of the same word.
        RREADY = 1'b0;
        issue_ar(32'h0, 4'd0, 3'd2, 2'b01);
        LD_EN   = 1'b1;
        LD_ADDR = 8'h00;
        LD_DATA = 32'h5555_5555;
        @(negedge G_clk);
        LD_EN = 1'b0;
        check("collide_rvalid", 32'(RVALID), 32'd1);
        check("collide_rdata", RDATA, mem_model[0]);
        exp_n       = 1;
        exp_resp    = 2'b00;
        exp_data[0] = mem_model[0];
        collect_beats(1'b0);
        mem_model[0] = 32'h5555_5555;
        run_model_burst(32'h0, 4'd0, 3'd2, 2'b01, 1'b0);

        // Upper LD_ADDR bits are dropped: 0x11 targets word 1.
        load_word(8'h11, 32'h7777_0001);
        run_model_burst(32'h0, 4'd3, 3'd2, 2'b01, 1'b0);

        // Randomised bursts against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] addr;
            logic [3:0]  len;
            logic [2:0]  size;
            logic [1:0]  burst;
            if ($urandom_range(0, 2) == 0) load_word(8'($urandom), $urandom);
            addr  = $urandom_range(0, 'h4F);
            len   = 4'($urandom_range(0, 15));
            size  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7))
                                                 : 3'($urandom_range(0, 2));
            burst = 2'($urandom_range(0, 3));
            run_model_burst(addr, len, size, burst, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_read_slave.md
AXI_READ_SLAVE -- requirements
Module: axi_read_slave

Interface
Parameters:
REQ-001 SHALL have parameter MEM_WORDS, default 16, meaning the number of 32-bit storage words (power of two, 2..256).
REQ-002 SHALL have parameter RD_LAT, default 1, meaning idle cycles inserted before each R beat (0..3).

Ports:
REQ-003 G_clk  in  1  single clock; all logic is on the rising edge.
REQ-004 G_reset  in  1  synchronous reset, active-high.
REQ-005 ARADDR  in  32  read start byte address.
REQ-006 ARLEN  in  4  burst length minus one.
REQ-007 ARSIZE  in  3  bytes per beat = 1<<ARSIZE.
REQ-008 ARBURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-009 ARVALID  in  1  address valid.
REQ-010 ARREADY  out  1  address accepted.
REQ-011 RREADY  in  1  master accepts the beat.
REQ-012 RVALID  out  1  beat valid.
REQ-013 RLAST  out  1  final beat of the burst.
REQ-014 RRESP  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR.
REQ-015 RDATA  out  32  read data.
REQ-016 slave_addr1, slave_addr2  in  32 each  inclusive decode range, low and high.
REQ-017 LD_EN, LD_ADDR, LD_DATA  in  1, 8, 32  backdoor word write into storage.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, BEAT: IDLE->WAIT (RD_LAT>0) or ->BEAT (RD_LAT=0) on AR handshake; WAIT->BEAT after RD_LAT cycles; BEAT->WAIT/BEAT on RVALID&RREADY when not last; BEAT->IDLE on a handshake with RLAST=1.
REQ-019 ARREADY SHALL be 1 only in IDLE; an AR handshake SHALL be ARVALID&ARREADY at a rising edge.
REQ-020 SHALL register ARADDR, ARLEN, ARSIZE and ARBURST at the handshake; later AR input changes SHALL have no effect until IDLE is re-entered.
REQ-021 With RD_LAT=0, RVALID SHALL assert in the cycle after the AR handshake; each RD_LAT adds one cycle before every beat.
REQ-022 Once asserted, RVALID, RDATA, RRESP and RLAST SHALL hold stable until RREADY=1 at a rising edge.
REQ-023 Beat count SHALL be ARLEN+1; RLAST SHALL be 1 only on beat index ARLEN.
REQ-024 The word index SHALL be addr[log2(MEM_WORDS)+1:2]; RDATA SHALL be the whole containing word, captured when the beat is presented.
REQ-025 Next address, FIXED: unchanged.
REQ-026 Next address, INCR: addr + (1<<size), modulo 2^32.
REQ-027 Next address, WRAP: container = (ARLEN+1)<<size, aligned down; the address SHALL wrap to the container base on crossing its top.
REQ-028 DECERR SHALL be returned on every beat, data 0, when the start address is outside [slave_addr1, slave_addr2].
REQ-029 Otherwise SLVERR SHALL be returned on every beat, data 0, when ARSIZE>2, ARBURST=11, or WRAP with ARLEN not in {1,3,7,15}.
REQ-030 A DECERR or SLVERR burst SHALL still issue ARLEN+1 beats.
REQ-031 A backdoor load in the same cycle as a beat capture of that word SHALL not alter the presented RDATA; the new value is visible from the next capture.
REQ-032 LD_ADDR bits above log2(MEM_WORDS) SHALL be ignored.

Reset
REQ-033 While G_reset=1 at an edge, the FSM SHALL go to IDLE and outputs SHALL be ARREADY=1, RVALID=0, RLAST=0, RRESP=00, RDATA=0.
REQ-034 Reset mid-burst SHALL abandon the burst with no further beats.
REQ-035 Reset SHALL NOT clear storage contents.

Structure
REQ-036 Package axi_pkg SHALL hold the burst and response encodings, the FSM state typedef and the 32-bit width constants.
REQ-037 Sub-module axi_rd_addr_gen SHALL compute the next address (combinational from addr, size, len, burst).

Verification
REQ-038 Load words 0..3 = 0xA0..0xA3; slave_addr1=0, slave_addr2=0x3F; INCR, ARADDR=0, ARLEN=3, ARSIZE=2, RREADY=1 -> RDATA A0,A1,A2,A3, RLAST on the 4th beat, RRESP=00.
REQ-039 WRAP, ARADDR=0x8, ARLEN=3, ARSIZE=2 -> words 2,3,0,1.
REQ-040 ARADDR=0x100, out of range, ARLEN=1 -> two beats, RRESP=11, RDATA=0.
REQ-041 RREADY=0 for 5 cycles during beat 1 -> RVALID/RDATA held stable; ARREADY=0 throughout.
REQ-042 ARSIZE=3 -> SLVERR; ARBURST=11 -> SLVERR; WRAP with ARLEN=2 -> SLVERR.
REQ-043 Assert G_reset during beat 2 of 4 -> RVALID=0 and ARREADY=1 next cycle; a re-read returns preserved data.
